// File: rtl/dds_serial_writer.sv
// -----------------------------------------------------------------------------
// dds_serial_writer
//
// Back-end of the DDS register path. When CEN is sampled high in IDLE, it takes
// a snapshot of the decoded register set. It then pulses the AD9854 serial-port
// resync line, writes seven register frames MSB first over the 3-wire serial
// port, and returns a one-cycle READY. The register slave raises the DDS
// I/O-update strobe itself after READY.
//
// Parameters
//   CLKDIV       SCLK half-period in CLK cycles (2..255)
//
// Ports
//   CLK          system clock
//   RST          synchronous, active-high reset
//   CEN          update request (level, held until READY)
//   F1H/F1L      FTW1 = {F1H,F1L}
//   F2H/F2L      FTW2 = {F2H,F2L}
//   DFWH/DFWL    delta-frequency word
//   PTW1/PTW2    phase offset words
//   RAMPRATE     ramp-rate clock word
//   MODE         DDS operating mode
//   TRAIANGLE    triangle enable
//   PLLEN        REFCLK multiplier enable
//   CLKMUILT     REFCLK multiplier
//   PLLRANGE     PLL range select
//   READY        one-cycle pulse at burst completion
//   BUSY         high from burst acceptance through READY
//   DDS_SCLK     serial clock (idles low)
//   DDS_SDIO     serial data
//   DDS_CS_N     chip select, active low
//   DDS_IORESET  serial-port resync pulse
// -----------------------------------------------------------------------------
module dds_serial_writer #(
    parameter int CLKDIV = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CEN,
    input  logic [15:0] F1H,
    input  logic [31:0] F1L,
    input  logic [15:0] F2H,
    input  logic [31:0] F2L,
    input  logic [15:0] DFWH,
    input  logic [31:0] DFWL,
    input  logic [13:0] PTW1,
    input  logic [13:0] PTW2,
    input  logic [19:0] RAMPRATE,
    input  logic [2:0]  MODE,
    input  logic        TRAIANGLE,
    input  logic        PLLEN,
    input  logic [4:0]  CLKMUILT,
    input  logic        PLLRANGE,
    output logic        READY,
    output logic        BUSY,
    output logic        DDS_SCLK,
    output logic        DDS_SDIO,
    output logic        DDS_CS_N,
    output logic        DDS_IORESET
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IORST,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE,
        S_WAITLOW
    } state_t;

    localparam logic [7:0] DIV_LOAD  = 8'(CLKDIV - 1);
    localparam logic [2:0] LAST_FRAME = 3'd6;

    // Index of the first (MSB) bit of each frame, instruction byte included.
    function automatic logic [5:0] frame_last_bit(input logic [2:0] idx);
        case (idx)
            3'd0:                 return 6'd39;  // CR
            3'd1, 3'd2:           return 6'd23;  // PTW1, PTW2
            3'd3, 3'd4, 3'd5:     return 6'd55;  // FTW1, FTW2, DFW
            default:              return 6'd31;  // RAMPRATE
        endcase
    endfunction

    // Control state
    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_nxt;
    logic [5:0]  bit_cnt, bit_nxt;
    logic [2:0]  frame_idx, frame_nxt;
    logic        sclk_q, sclk_nxt;

    // Datapath strobes
    logic        snap;
    logic        load;
    logic        shift;

    // Shadow copy of the register set, frozen for the whole burst
    logic [47:0] sh_f1;
    logic [47:0] sh_f2;
    logic [47:0] sh_dfw;
    logic [13:0] sh_ptw1;
    logic [13:0] sh_ptw2;
    logic [19:0] sh_ramp;
    logic [2:0]  sh_mode;
    logic        sh_tri;
    logic        sh_pllen;
    logic [4:0]  sh_mult;
    logic        sh_range;

    // Frame shift register, left-aligned so the current bit is always [55]
    logic [55:0] sreg;
    logic [55:0] load_word;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            div_cnt   <= 8'd0;
            bit_cnt   <= 6'd0;
            frame_idx <= 3'd0;
            sclk_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            frame_idx <= frame_nxt;
            sclk_q    <= sclk_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        frame_nxt = frame_idx;
        sclk_nxt  = sclk_q;
        snap      = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;

        case (state)
            S_IDLE: begin
                if (CEN) begin
                    snap      = 1'b1;
                    state_nxt = S_IORST;
                    div_nxt   = DIV_LOAD;
                    // IORESET spans two divider rounds; 2*CLKDIV can
                    // exceed the 8-bit divider, so the bit counter counts rounds.
                    bit_nxt   = 6'd1;
                end
            end

            S_IORST: begin
                if (div_cnt == 8'd0) begin
                    div_nxt = DIV_LOAD;
                    if (bit_cnt == 6'd0) begin
                        state_nxt = S_SETUP;
                        frame_nxt = 3'd0;
                        load      = 1'b1;
                        bit_nxt   = frame_last_bit(3'd0);
                    end else begin
                        bit_nxt = bit_cnt - 6'd1;
                    end
                end else begin
                    div_nxt = div_cnt - 8'd1;
                end
            end

            S_SETUP: begin
                if (div_cnt == 8'd0) begin
                    state_nxt = S_SHIFT;
                    sclk_nxt  = 1'b1;
                    div_nxt   = DIV_LOAD;
                end else begin
                    div_nxt = div_cnt - 8'd1;
                end
            end

            S_SHIFT: begin
                if (div_cnt == 8'd0) begin
                    div_nxt = DIV_LOAD;
                    if (sclk_q) begin
                        // End of high phase: SDIO moves to the next bit in
                        // the first low cycle, never while SCLK is high.
                        sclk_nxt = 1'b0;
                        shift    = 1'b1;
                    end else if (bit_cnt == 6'd0) begin
                        state_nxt = S_GAP;
                    end else begin
                        bit_nxt  = bit_cnt - 6'd1;
                        sclk_nxt = 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt - 8'd1;
                end
            end

            S_GAP: begin
                if (div_cnt == 8'd0) begin
                    if (frame_idx == LAST_FRAME) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_SETUP;
                        frame_nxt = frame_idx + 3'd1;
                        load      = 1'b1;
                        bit_nxt   = frame_last_bit(frame_idx + 3'd1);
                        div_nxt   = DIV_LOAD;
                    end
                end else begin
                    div_nxt = div_cnt - 8'd1;
                end
            end

            S_DONE: begin
                state_nxt = S_WAITLOW;
            end

            S_WAITLOW: begin
                // A level-held CEN must drop before the next request counts.
                if (!CEN) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame image selection (instruction byte followed by data, MSB first)
    // -------------------------------------------------------------------------
    always_comb begin
        load_word = 56'd0;
        case (frame_nxt)
            // CR: external update clock, comparator down, MSB-first 3-wire.
            3'd0: load_word = {8'h07, 8'h10,
                               {1'b0, sh_range, ~sh_pllen, sh_mult},
                               {2'b00, sh_tri, 1'b0, sh_mode, 1'b0},
                               8'h00, 16'h0000};
            3'd1: load_word = {8'h00, 2'b00, sh_ptw1, 32'h0};
            3'd2: load_word = {8'h01, 2'b00, sh_ptw2, 32'h0};
            3'd3: load_word = {8'h02, sh_f1};
            3'd4: load_word = {8'h03, sh_f2};
            3'd5: load_word = {8'h04, sh_dfw};
            default: load_word = {8'h06, 4'h0, sh_ramp, 24'h0};
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers (shadow set and shifter)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (snap) begin
            sh_f1    <= {F1H, F1L};
            sh_f2    <= {F2H, F2L};
            sh_dfw   <= {DFWH, DFWL};
            sh_ptw1  <= PTW1;
            sh_ptw2  <= PTW2;
            sh_ramp  <= RAMPRATE;
            sh_mode  <= MODE;
            sh_tri   <= TRAIANGLE;
            sh_pllen <= PLLEN;
            sh_mult  <= CLKMUILT;
            sh_range <= PLLRANGE;
        end
        if (load) begin
            sreg <= load_word;
        end else if (shift) begin
            sreg <= {sreg[54:0], 1'b0};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from registered state
    // -------------------------------------------------------------------------
    assign READY       = (state == S_DONE);
    assign BUSY        = (state == S_IORST) || (state == S_SETUP) ||
                         (state == S_SHIFT) || (state == S_GAP)   ||
                         (state == S_DONE);
    assign DDS_IORESET = (state == S_IORST);
    assign DDS_CS_N    = !((state == S_SETUP) || (state == S_SHIFT));
    assign DDS_SCLK    = sclk_q;
    assign DDS_SDIO    = ((state == S_SETUP) || (state == S_SHIFT)) ? sreg[55] : 1'b0;

endmodule
